// File: rtl/alu_accu_core.sv
// alu_accu_core: parametrised accumulator ALU datapath.
//   Register file, accumulator and carry/zero flags behind a valid/ready op port. An op is
//   accepted in IDLE, executes in EXEC (1 cycle) or MUL (WIDTH cycles), then writes back.
//   Optional feature: define ALU_MUL_EN to turn opcode 111 into a shift-add unsigned MUL;
//   without it opcode 111 is SHR and mul_hi stays 0.
// Ports:
//   clk, reset (sync, active-high)
//   op_valid / op_ready            op handshake (ready only in IDLE)
//   opcode, src_sel                operation and operand source
//   acumulator_ce, reg_file_ce     write-back enables, captured at acceptance
//   reg_file_adr                   rf read / write-back / direct-load address
//   reg_file_data_in, direct_load  direct register load
//   data_memory, data_direct       operand sources
//   alu_result, acu_output         last result, accumulator
//   register_file_output           combinational rf[reg_file_adr]
//   alu_argument                   operand captured at acceptance
//   c_out, z_out, mul_hi, done     flags, MUL upper half, completion pulse
module alu_accu_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned REGS  = 4,
    localparam int unsigned AW   = (REGS > 1) ? $clog2(REGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       opcode,
    input  logic [1:0]       src_sel,
    input  logic             acumulator_ce,
    input  logic             reg_file_ce,
    input  logic [AW-1:0]    reg_file_adr,
    input  logic [WIDTH-1:0] reg_file_data_in,
    input  logic             direct_load,
    input  logic [WIDTH-1:0] data_memory,
    input  logic [WIDTH-1:0] data_direct,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] acu_output,
    output logic [WIDTH-1:0] register_file_output,
    output logic [WIDTH-1:0] alu_argument,
    output logic             c_out,
    output logic             z_out,
    output logic [WIDTH-1:0] mul_hi,
    output logic             done
);

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;
`else
    typedef enum logic [1:0] {StIdle, StExec} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rf_q [REGS];
    logic [WIDTH-1:0] acc_q, res_q, arg_q, a_q;
    logic [2:0]       op_q;
    logic             ace_q, rce_q, c_q, z_q, done_q;
    logic [AW-1:0]    wadr_q;

    logic             accept, complete, mul_last;
    logic             rd_adr_ok, wb_adr_ok;
    logic [WIDTH-1:0] rf_rd, operand;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] ex_res, fin_res;
    logic             ex_c, fin_c;

    assign op_ready  = (state_q == StIdle);
    assign accept    = op_valid & op_ready;
    // Widen before comparing so non-power-of-two depths drop out-of-range accesses.
    assign rd_adr_ok = 32'(reg_file_adr) < REGS;
    assign wb_adr_ok = 32'(wadr_q) < REGS;
    assign rf_rd     = rd_adr_ok ? rf_q[reg_file_adr] : '0;

    always_comb begin
        operand = '0;
        unique case (src_sel)
            2'd0:    operand = rf_rd;
            2'd1:    operand = data_memory;
            2'd2:    operand = data_direct;
            default: operand = '0;
        endcase
    end

    // Single-cycle ops work on the snapshot (a_q) and captured argument (arg_q).
    always_comb begin
        ext    = '0;
        ex_res = '0;
        ex_c   = 1'b0;
        case (op_q)
            3'b000: ex_res = arg_q;
            3'b001: begin
                ext    = {1'b0, a_q} + {1'b0, arg_q};
                ex_res = ext[WIDTH-1:0];
                ex_c   = ext[WIDTH];
            end
            3'b010: begin
                // Top bit of the widened difference is the borrow.
                ext    = {1'b0, a_q} - {1'b0, arg_q};
                ex_res = ext[WIDTH-1:0];
                ex_c   = ext[WIDTH];
            end
            3'b011: ex_res = a_q & arg_q;
            3'b100: ex_res = a_q | arg_q;
            3'b101: ex_res = a_q ^ arg_q;
            3'b110: begin
                ex_res = {a_q[WIDTH-2:0], 1'b0};
                ex_c   = a_q[WIDTH-1];
            end
            default: begin
                ex_res = {1'b0, a_q[WIDTH-1:1]};
                ex_c   = a_q[0];
            end
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);

    // prod_q holds {partial sum, remaining multiplier bits}; one bit retired per cycle.
    logic [2*WIDTH-1:0] prod_q, prod_step;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     psum;
    logic [WIDTH-1:0]   hi_q;

    assign psum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){prod_q[0]}} & {1'b0, a_q});
    assign prod_step = {psum, prod_q[WIDTH-1:1]};
    assign mul_last  = (state_q == StMul) && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
        end else begin
            if (accept) begin
                prod_q <= {{WIDTH{1'b0}}, operand};
                cnt_q  <= '0;
            end else if (state_q == StMul) begin
                prod_q <= prod_step;
                cnt_q  <= cnt_q + 1'b1;
            end
            if (mul_last) hi_q <= prod_step[2*WIDTH-1:WIDTH];
        end
    end

    assign mul_hi = hi_q;

    always_comb begin
        fin_res = ex_res;
        fin_c   = ex_c;
        if (mul_last) begin
            fin_res = prod_step[WIDTH-1:0];
            fin_c   = |prod_step[2*WIDTH-1:WIDTH];
        end
    end
`else
    assign mul_last = 1'b0;
    assign mul_hi   = '0;
    assign fin_res  = ex_res;
    assign fin_c    = ex_c;
`endif

    assign complete = (state_q == StExec) | mul_last;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
`ifdef ALU_MUL_EN
                    state_d = (opcode == 3'b111) ? StMul : StExec;
`else
                    state_d = StExec;
`endif
                end
            end
            StExec: state_d = StIdle;
`ifdef ALU_MUL_EN
            StMul: if (mul_last) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < REGS; i++) rf_q[i] <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            arg_q  <= '0;
            a_q    <= '0;
            op_q   <= '0;
            ace_q  <= 1'b0;
            rce_q  <= 1'b0;
            wadr_q <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= opcode;
                arg_q  <= operand;
                a_q    <= acc_q;
                ace_q  <= acumulator_ce;
                rce_q  <= reg_file_ce;
                wadr_q <= reg_file_adr;
            end
            done_q <= complete;
            if (direct_load && rd_adr_ok) rf_q[reg_file_adr] <= reg_file_data_in;
            if (complete) begin
                res_q <= fin_res;
                c_q   <= fin_c;
                z_q   <= (fin_res == '0);
                if (ace_q) acc_q <= fin_res;
                // Later assignment: ALU write-back wins over a same-address direct load.
                if (rce_q && wb_adr_ok) rf_q[wadr_q] <= fin_res;
            end
        end
    end

    assign alu_result           = res_q;
    assign acu_output           = acc_q;
    assign register_file_output = rf_rd;
    assign alu_argument         = arg_q;
    assign c_out                = c_q;
    assign z_out                = z_q;
    assign done                 = done_q;

endmodule
